seg7_reader: RTL and testbench

Observes a multiplexed, active-low 7-segment display bus and recovers the displayed value. It qualifies each digit's segment pattern for stability, decodes it back to a 5-bit code (hex 0x0–0xF, blank, or unrecognised), and stores it per digit. Each capture is also offered on a valid/ready stream. It sits on the board-test / self-check path, on the far side of the hex-to-segment display driver.

---
 rtl/seg7_reader.sv | 232 +++++++++++++++++++++++
 tb/tb_seg7_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_reader.sv
`timescale 1ns/1ps
// seg7_reader
//
// Watches a multiplexed, active-low 7-segment display bus and recovers the
// value being shown. Each digit's pattern must hold for STABLE_CYCLES
// consecutive samples before it is decoded into a 5-bit code (0x00-0x0F hex,
// 0x10 blank, 0x1F unrecognised). The code is stored per digit and offered
// on a one-entry valid/ready stream.
//
// Ports
//   clk, rst_n   : clock and synchronous active-low reset
//   seg          : segment lines, active-low, bit0 = a ... bit6 = g
//   dig_en_n     : digit selects, active-low; exactly one low is a valid select
//   out_valid    : stream entry available
//   out_ready    : consumer accepts the entry
//   out_digit    : digit index of the stream entry
//   out_code     : decoded code of the stream entry
//   digits       : latest code per digit, digit i at [5i+4:5i]
//   frame_pulse  : one-cycle pulse on capture of digit NUM_DIGITS-1
//   overflow     : sticky, a capture was dropped because the buffer was full
//
// Build option
//   SEG7_READER_CHANGE_ONLY_EN : when defined, a capture whose code matches the
//   stored code for that digit is not offered on the stream (frame_pulse still
//   fires). When undefined, every capture is offered.
module seg7_reader #(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg,
   input  logic [NUM_DIGITS-1:0]   dig_en_n,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2:0]              out_digit,
   output logic [4:0]              out_code,
   output logic [5*NUM_DIGITS-1:0] digits,
   output logic                    frame_pulse,
   output logic                    overflow
);

   localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
   localparam int unsigned SmpW = 7 + NUM_DIGITS;

   typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

   function automatic logic [4:0] seg_decode(input logic [6:0] s);
      case (s)
         7'b1000000: return 5'h00;
         7'b1111001: return 5'h01;
         7'b0100100: return 5'h02;
         7'b0110000: return 5'h03;
         7'b0011001: return 5'h04;
         7'b0010010: return 5'h05;
         7'b0000010: return 5'h06;
         7'b1111000: return 5'h07;
         7'b0000000: return 5'h08;
         7'b0010000: return 5'h09;
         7'b0001000: return 5'h0A;
         7'b0000011: return 5'h0B;
         7'b1000110: return 5'h0C;
         7'b0100001: return 5'h0D;
         7'b0000110: return 5'h0E;
         7'b0001110: return 5'h0F;
         7'b1111111: return 5'h10;
         default:    return 5'h1F;
      endcase
   endfunction

   // Sample stage: holds the previous sample of the bus. Change detection
   // compares the sample being taken at this edge against it, so a pattern
   // first registered at edge k+1 counts 1 there and is captured at the
   // edge where the count reaches STABLE_CYCLES.
   logic [SmpW-1:0] smp_q;
   logic            changed;
   logic [3:0]      sel_cnt;
   logic            sel_ok;
   logic [2:0]      cap_idx;
   logic [4:0]      cap_code;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            capture;

   logic [4:0]      dig_q [NUM_DIGITS];
   logic [4:0]      dig_d [NUM_DIGITS];
   logic            offer;

   logic            valid_q, valid_d;
   logic [2:0]      digit_q, digit_d;
   logic [4:0]      code_q, code_d;
   logic            frame_q, frame_d;
   logic            ovf_q, ovf_d;

   assign changed  = ({seg, dig_en_n} != smp_q);
   assign cap_code = seg_decode(smp_q[SmpW-1 -: 7]);

   always_comb begin
      sel_cnt = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!dig_en_n[i]) sel_cnt = sel_cnt + 4'd1;
      end
      sel_ok  = (sel_cnt == 4'd1);
      // Capture only happens when the sample is unchanged, so the index can
      // be taken from the registered select.
      cap_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!smp_q[i]) cap_idx = 3'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (sel_ok) begin
               state_d = StSettle;
               cnt_d   = CntW'(1);
            end
         end
         StSettle: begin
            if (!sel_ok) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (changed) begin
               cnt_d = CntW'(1);
            end else begin
               cnt_d = cnt_q + CntW'(1);
               if (cnt_d == CntMax) begin
                  capture = 1'b1;
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (!sel_ok) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (changed) begin
               state_d = StSettle;
               cnt_d   = CntW'(1);
            end else begin
               cnt_d = CntMax;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         dig_d[i] = dig_q[i];
         if (capture && (cap_idx == 3'(i))) dig_d[i] = cap_code;
      end
   end

`ifdef SEG7_READER_CHANGE_ONLY_EN
   logic [4:0] cur_code;
   always_comb begin
      cur_code = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (cap_idx == 3'(i)) cur_code = dig_q[i];
      end
   end
   assign offer = capture && (cap_code != cur_code);
`else
   assign offer = capture;
`endif

   always_comb begin
      valid_d = valid_q;
      digit_d = digit_q;
      code_d  = code_q;
      ovf_d   = ovf_q;
      frame_d = capture && (cap_idx == 3'(NUM_DIGITS - 1));
      if (offer) begin
         // A transfer on the same edge frees the slot for the new entry.
         if (!valid_q || out_ready) begin
            valid_d = 1'b1;
            digit_d = cap_idx;
            code_d  = cap_code;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         smp_q   <= '1;
         state_q <= StIdle;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         digit_q <= '0;
         code_q  <= '0;
         frame_q <= 1'b0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= 5'h10;
      end else begin
         smp_q   <= {seg, dig_en_n};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         digit_q <= digit_d;
         code_q  <= code_d;
         frame_q <= frame_d;
         ovf_q   <= ovf_d;
         for (int i = 0; i < NUM_DIGITS; i++) dig_q[i] <= dig_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) digits[5*i +: 5] = dig_q[i];
   end

   assign out_valid   = valid_q;
   assign out_digit   = digit_q;
   assign out_code    = code_q;
   assign frame_pulse = frame_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_seg7_reader.sv
`timescale 1ns/1ps
// Directed bench for seg7_reader with NUM_DIGITS=4, STABLE_CYCLES=8.
module tb_seg7_reader;

   logic        clk;
   logic        rst_n;
   logic [6:0]  seg;
   logic [3:0]  dig_en_n;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_digit;
   logic [4:0]  out_code;
   logic [19:0] digits;
   logic        frame_pulse;
   logic        overflow;

   int n_vec;
   int n_err;

   logic [4:0] xfer_q [$];
   int         frame_cnt;
   logic [2:0] frame_dig;
   logic       valid_seen;

   seg7_reader #(
      .NUM_DIGITS   (4),
      .STABLE_CYCLES(8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seg        (seg),
      .dig_en_n   (dig_en_n),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_digit  (out_digit),
      .out_code   (out_code),
      .digits     (digits),
      .frame_pulse(frame_pulse),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges, sampling 1 ns after each edge.
   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         if (out_valid && out_ready) xfer_q.push_back(out_code);
         if (frame_pulse) begin
            frame_cnt++;
            frame_dig = out_digit;
         end
         if (out_valid) valid_seen = 1'b1;
      end
   endtask

   logic [6:0] scan_pat  [4];
   logic [4:0] scan_code [4];
   int         exp_n;

   initial begin
      n_vec      = 0;
      n_err      = 0;
      frame_cnt  = 0;
      frame_dig  = '0;
      valid_seen = 1'b0;
      scan_pat   = '{7'b0100100, 7'b1000000, 7'b0001110, 7'b1111111};
      scan_code  = '{5'h02, 5'h00, 5'h0F, 5'h10};

      // Reset with digit 0 showing 8.
      rst_n     = 1'b0;
      seg       = 7'b0000000;
      dig_en_n  = 4'b1110;
      out_ready = 1'b0;
      run(3);
      rst_n = 1'b1;
      chk("rst_valid",    32'(out_valid),   32'd0);
      chk("rst_digits",   32'(digits),      32'h84210);
      chk("rst_code",     32'(out_code),    32'd0);
      chk("rst_overflow", 32'(overflow),    32'd0);
      run(7);
      chk("pre_cap_valid", 32'(out_valid), 32'd0);
      run(1);
      chk("cap8_valid", 32'(out_valid),   32'd1);
      chk("cap8_digit", 32'(out_digit),   32'd0);
      chk("cap8_code",  32'(out_code),    32'h08);
      chk("cap8_dig0",  32'(digits[4:0]), 32'h08);
      out_ready = 1'b1;
      run(1);
      chk("drain_valid", 32'(out_valid), 32'd0);

      // Scan digits 0..3 with 2, 0, F, blank.
      xfer_q.delete();
      frame_cnt = 0;
      for (int d = 0; d < 4; d++) begin
         seg      = scan_pat[d];
         dig_en_n = ~(4'b0001 << d);
         run(20);
      end
`ifdef SEG7_READER_CHANGE_ONLY_EN
      exp_n = 3;  // digit 3 was already blank
`else
      exp_n = 4;
`endif
      chk("scan_xfers", 32'(xfer_q.size()), 32'(exp_n));
      for (int i = 0; i < exp_n; i++) begin
         chk($sformatf("scan_code%0d", i),
             (i < xfer_q.size()) ? 32'(xfer_q[i]) : 32'hFFFF, 32'(scan_code[i]));
      end
      chk("scan_frames",    32'(frame_cnt), 32'd1);
      chk("scan_frame_dig", 32'(frame_dig), 32'd3);
      chk("scan_digits",    32'(digits),    32'({5'h10, 5'h0F, 5'h00, 5'h02}));

      // Toggle faster than the stability window: nothing captured.
      valid_seen = 1'b0;
      dig_en_n   = 4'b1110;
      for (int t = 0; t < 4; t++) begin
         seg = (t % 2 == 1) ? 7'b1111001 : 7'b0000000;
         run(5);
      end
      chk("toggle_valid",  32'(valid_seen), 32'd0);
      chk("toggle_digits", 32'(digits),     32'({5'h10, 5'h0F, 5'h00, 5'h02}));
      seg = 7'b1111110;
      run(7);
      chk("bad_pre_valid", 32'(out_valid), 32'd0);
      run(1);
      chk("bad_valid", 32'(out_valid), 32'd1);
      chk("bad_code",  32'(out_code),  32'h1F);
      run(1);

      // Stalled consumer, then ready raised on the capture edge.
      out_ready = 1'b0;
      dig_en_n  = 4'b1101;
      seg       = 7'b0110000;
      run(8);
      chk("stallA_valid", 32'(out_valid), 32'd1);
      chk("stallA_code",  32'(out_code),  32'h03);
      dig_en_n = 4'b1011;
      seg      = 7'b0011001;
      run(7);
      out_ready = 1'b1;
      run(1);
      chk("coinc_valid", 32'(out_valid), 32'd1);
      chk("coinc_digit", 32'(out_digit), 32'd2);
      chk("coinc_code",  32'(out_code),  32'h04);
      chk("coinc_ovf",   32'(overflow),  32'd0);
      out_ready = 1'b0;
      dig_en_n  = 4'b0111;
      seg       = 7'b0010010;
      run(8);
      chk("drop_ovf",   32'(overflow),       32'd1);
      chk("drop_digit", 32'(out_digit),      32'd2);
      chk("drop_code",  32'(out_code),       32'h04);
      chk("drop_dig3",  32'(digits[19:15]),  32'h05);
      chk("drop_frame", 32'(frame_pulse),    32'd1);
      run(1);
      chk("frame_one_cycle", 32'(frame_pulse), 32'd0);

      // Invalid selects keep the reader idle.
      out_ready = 1'b1;
      dig_en_n  = 4'b1100;
      seg       = 7'b0000000;
      run(1);
      valid_seen = 1'b0;
      run(11);
      dig_en_n = 4'b1111;
      run(12);
      chk("idle_valid",  32'(valid_seen), 32'd0);
      chk("idle_digits", 32'(digits),     32'({5'h05, 5'h04, 5'h03, 5'h1F}));

      // Reset mid-settle with an entry pending.
      out_ready = 1'b0;
      dig_en_n  = 4'b1110;
      seg       = 7'b0000000;
      run(8);
      chk("pend_valid", 32'(out_valid), 32'd1);
      seg = 7'b1111001;
      run(3);
      rst_n = 1'b0;
      run(1);
      chk("mid_rst_valid",  32'(out_valid),   32'd0);
      chk("mid_rst_digit",  32'(out_digit),   32'd0);
      chk("mid_rst_code",   32'(out_code),    32'd0);
      chk("mid_rst_frame",  32'(frame_pulse), 32'd0);
      chk("mid_rst_ovf",    32'(overflow),    32'd0);
      chk("mid_rst_digits", 32'(digits),      32'h84210);
      rst_n = 1'b1;
      run(7);
      chk("post_rst_pre_valid", 32'(out_valid), 32'd0);
      run(1);
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_code",  32'(out_code),  32'h01);

      // Same code captured twice on digit 0.
      out_ready = 1'b1;
      run(1);
      xfer_q.delete();
      seg      = 7'b0010010;
      dig_en_n = 4'b1110;
      run(12);
      dig_en_n = 4'b1111;
      run(4);
      dig_en_n = 4'b1110;
      run(12);
`ifdef SEG7_READER_CHANGE_ONLY_EN
      exp_n = 1;
`else
      exp_n = 2;
`endif
      chk("repeat_xfers", 32'(xfer_q.size()), 32'(exp_n));
      chk("repeat_dig0",  32'(digits[4:0]),   32'h05);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
